if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage controller for the pipelined MIPS core.
//  - Consumes the PC register's output and drives its next value and write-enable (pc_next/pc_we -> PC reg d/e).
//  - Runs a req/ack handshake to instruction memory.
//  - Buffers fetched words in a small FIFO and presents them to the ID stage with valid/ready.
//  - Handles branch/jump redirects, including discarding an in-flight fetch.
// PARAMETERS
//  DEPTH   2   instruction buffer entries (>=1); limits fetch-ahead
//  PC_INC  4   sequential PC increment in bytes
// PORTS
//  clk          in   1   rising-edge clock
//  clrn         in   1   asynchronous active-low reset
//  pc           in   32  current PC (PC register q)
//  pc_next      out  32  next PC value (PC register d)
//  pc_we        out  1   PC register write enable (PC register e)
//  redirect     in   1   branch taken / jump, from ID/EX
//  redirect_pc  in   32  target PC for redirect
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  fetch address; stable while imem_req=1
//  imem_ack     in   1   completes the request this cycle; imem_rdata valid
//  imem_rdata   in   32  fetched instruction word
//  ins_valid    out  1   ins/ins_pc4 valid to ID
//  id_ready     in   1   ID accepts the head entry (pop = ins_valid & id_ready)
//  ins          out  32  instruction word at FIFO head
//  ins_pc4      out  32  fetch address + PC_INC of head entry
// BEHAVIOUR
//  Reset (clrn=0, async):
//   - FSM=IDLE, count=0, imem_req=0, imem_addr=0, ins_valid=0, ins=0, ins_pc4=0.
//   - pc_we=0 and pc_next=0 while clrn=0.
//  FSM (registered): IDLE, WAIT, DROP.
//   - IDLE: no request. If count<DEPTH and !redirect -> WAIT; imem_req<=1, imem_addr<=pc.
//   - WAIT, imem_ack=0: hold req/addr. redirect=1 -> DROP.
//   - WAIT, imem_ack=1, redirect=0:
//     - Push {imem_addr+PC_INC, imem_rdata}; pc_we=1, pc_next=pc+PC_INC.
//     - If count+1-pop < DEPTH: stay WAIT, imem_addr<=pc+PC_INC (back-to-back, 1 insn/cycle).
//     - Else -> IDLE, imem_req<=0.
//   - WAIT, imem_ack=1, redirect=1: data dropped -> IDLE.
//   - DROP: req/addr held; on imem_ack data discarded -> IDLE. Redirect in DROP is taken, stay DROP.
//  Redirect (any state):
//   - pc_we=1, pc_next=redirect_pc; overrides any sequential update that cycle.
//   - FIFO flushed (count<=0); a pop in the same cycle is ignored.
//   - No fetch is issued that cycle; the first fetch from the target is issued on the IDLE->WAIT edge.
//  pc_we/pc_next are combinational. pc_we=0 and pc_next=pc when no redirect and no accepted ack.
//  FIFO:
//   - ins_valid=(count!=0); ins/ins_pc4 show the head entry.
//   - Push and pop in the same cycle are allowed; count unchanged.
//   - Overflow is impossible: an issue requires a free slot.
//  Arithmetic: all adds are 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
//  imem_ack while imem_req=0 is ignored.
// STRUCTURE
//  - mips_pkg: WORD_W=32, PC_INC default, FSM state encoding localparams.
//  - One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO of {pc4, insn} with flush, async clrn.
//  - Top level holds the FSM, the handshake registers and the PC mux.
// TESTING
//  1. Reset, pc=0, ack tied 1, id_ready=1:
//     - imem_addr 0,4,8,... on consecutive cycles, pc_we=1 each cycle.
//     - ins_pc4 = addr+4, one insn per cycle.
//  2. id_ready=0, ack=1, DEPTH=2:
//     - Two pushes, then imem_req drops, ins_valid=1, pc frozen (pc_we=0).
//     - Raising id_ready resumes fetching.
//  3. Ack latency 3 cycles:
//     - imem_req/imem_addr stable for all 3 cycles; exactly one push; pc advances by 4 once.
//  4. Redirect to 0x400 while in WAIT:
//     - pc_next=0x400, pc_we=1; ins_valid=0 next cycle.
//     - The late ack data never appears on ins; next imem_addr=0x400.
//  5. Redirect coincident with ack and pop:
//     - Ack data dropped, FIFO empty, pc_next=redirect_pc (not pc+4).
//  6. clrn pulsed low mid-WAIT:
//     - imem_req=0, ins_valid=0 immediately (async).
//     - Fetch restarts from pc after release.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the word width, default PC step, FSM encoding and the buffered entry layout.
package if_fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC_DEF = 32'd4;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory is the slave.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous buffer of fetched {pc4, insn} entries with a one-cycle flush.
// Flush dominates push and pop issued in the same cycle.
module if_fetch_unit_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign valid = (count_q != '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: issues imem requests, buffers returned words for ID and steers the PC register.
//   state | meaning
//   IDLE  | no request outstanding; issue when a buffer slot is free
//   WAIT  | request outstanding; ack pushes the word and may chain the next fetch
//   DROP  | request outstanding after a redirect; ack data is discarded
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                DEPTH  = DEPTH_DEF,
    parameter logic [WORD_W-1:0] PC_INC = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_next,
    output logic              pc_we,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic              ins_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] ins,
    output logic [WORD_W-1:0] ins_pc4
);

    localparam int          CNT_W   = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              pop;
    logic [31:0]       fill_after;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign imem.req   = (state_q != ST_IDLE);
    assign imem.addr  = addr_q;
    assign accept     = (state_q == ST_WAIT) && imem.ack && !redirect;
    assign pop        = ins_valid && id_ready && !redirect;
    assign fill_after = 32'(count) + 32'd1 - 32'(pop);
    assign push_entry = '{pc4: addr_q + PC_INC, insn: imem.rdata};

    // Redirect wins over the sequential step; PC write is held off during reset.
    always_comb begin
        pc_we   = 1'b0;
        pc_next = pc;
        if (!clrn) begin
            pc_next = '0;
        end else if (redirect) begin
            pc_we   = 1'b1;
            pc_next = redirect_pc;
        end else if (accept) begin
            pc_we   = 1'b1;
            pc_next = pc + PC_INC;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (!redirect && (32'(count) < DEPTH_U)) begin
                    state_d = ST_WAIT;
                    addr_d  = pc;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = imem.ack ? ST_IDLE : ST_DROP;
                end else if (imem.ack) begin
                    if (fill_after < DEPTH_U) addr_d = pc + PC_INC;
                    else                      state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem.ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    if_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (redirect),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .valid     (ins_valid),
        .head      (head)
    );

    assign ins     = head.insn;
    assign ins_pc4 = head.pc4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: models the PC register and an imem returning ~addr.
// Expected values are hand-computed per cycle.
module tb_if_fetch_unit;

    logic        clk;
    logic        clrn;
    logic        pc_rst_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ack_drv;
    logic        ins_valid;
    logic        id_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc4;

    int n_chk = 0;
    int n_err = 0;

    if_fetch_unit_if bus ();

    assign bus.ack   = ack_drv;
    assign bus.rdata = ~bus.addr;

    if_fetch_unit dut (
        .clk         (clk),
        .clrn        (clrn),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_we       (pc_we),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .ins_valid   (ins_valid),
        .id_ready    (id_ready),
        .ins         (ins),
        .ins_pc4     (ins_pc4)
    );

    // PC register has its own reset so a fetch-unit reset leaves it intact.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n)  pc <= '0;
        else if (pc_we) pc <= pc_next;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn        = 1'b0;
        pc_rst_n    = 1'b0;
        ack_drv     = 1'b0;
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h123;
        #1;
        chk("rst_req",     32'(bus.req),   32'd0);
        chk("rst_addr",    bus.addr,       32'd0);
        chk("rst_valid",   32'(ins_valid), 32'd0);
        chk("rst_ins",     ins,            32'd0);
        chk("rst_pc4",     ins_pc4,        32'd0);
        chk("rst_pc_we",   32'(pc_we),     32'd0);
        chk("rst_pc_next", pc_next,        32'd0);
        redirect = 1'b0;
        ack_drv  = 1'b1;
        id_ready = 1'b1;
        #11;
        clrn     = 1'b1;
        pc_rst_n = 1'b1;
        tick();

        // 1: streaming, one word per cycle
        for (int k = 0; k < 5; k++) begin
            chk("t1_req",  32'(bus.req), 32'd1);
            chk("t1_addr", bus.addr,     32'(4 * k));
            chk("t1_we",   32'(pc_we),   32'd1);
            chk("t1_next", pc_next,      32'(4 * k + 4));
            if (k > 0) begin
                chk("t1_pc4", ins_pc4, 32'(4 * k));
                chk("t1_ins", ins,     ~32'(4 * (k - 1)));
            end else begin
                chk("t1_valid0", 32'(ins_valid), 32'd0);
            end
            tick();
        end

        // 2: back-pressure fills the buffer, then resume
        id_ready = 1'b0;
        #1;
        chk("t2_we",   32'(pc_we), 32'd1);
        chk("t2_next", pc_next,    32'd24);
        tick();
        chk("t2_req",   32'(bus.req),   32'd0);
        chk("t2_valid", 32'(ins_valid), 32'd1);
        chk("t2_we0",   32'(pc_we),     32'd0);
        chk("t2_next0", pc_next,        32'd24);
        chk("t2_pc4",   ins_pc4,        32'd20);
        tick();
        chk("t2_hold_req", 32'(bus.req), 32'd0);
        chk("t2_hold_pc",  pc,           32'd24);
        id_ready = 1'b1;
        tick();
        chk("t2_pc4b",  ins_pc4,      32'd24);
        chk("t2_req_b", 32'(bus.req), 32'd0);
        tick();
        chk("t2_resume_req",  32'(bus.req),   32'd1);
        chk("t2_resume_addr", bus.addr,       32'd24);
        chk("t2_empty",       32'(ins_valid), 32'd0);

        // 3: three-cycle ack latency
        ack_drv  = 1'b0;
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t3_req",  32'(bus.req), 32'd1);
            chk("t3_addr", bus.addr,     32'd24);
            chk("t3_we",   32'(pc_we),   32'd0);
            tick();
        end
        ack_drv = 1'b1;
        #1;
        chk("t3_req_ack",  32'(bus.req), 32'd1);
        chk("t3_addr_ack", bus.addr,     32'd24);
        chk("t3_we_ack",   32'(pc_we),   32'd1);
        chk("t3_next_ack", pc_next,      32'd28);
        tick();
        ack_drv = 1'b0;
        #1;
        chk("t3_valid", 32'(ins_valid), 32'd1);
        chk("t3_pc4",   ins_pc4,        32'd28);
        chk("t3_ins",   ins,            ~32'd24);
        chk("t3_pc",    pc,             32'd28);
        chk("t3_addr2", bus.addr,       32'd28);

        // 4: redirect while waiting; late ack discarded
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        #1;
        chk("t4_we",   32'(pc_we), 32'd1);
        chk("t4_next", pc_next,    32'h400);
        tick();
        redirect = 1'b0;
        #1;
        chk("t4_flush", 32'(ins_valid), 32'd0);
        chk("t4_req",   32'(bus.req),   32'd1);
        chk("t4_addr",  bus.addr,       32'd28);
        ack_drv = 1'b1;
        #1;
        chk("t4_drop_we", 32'(pc_we), 32'd0);
        tick();
        ack_drv = 1'b0;
        #1;
        chk("t4_idle_req", 32'(bus.req),   32'd0);
        chk("t4_valid",    32'(ins_valid), 32'd0);
        chk("t4_pc",       pc,             32'h400);
        tick();
        chk("t4_req2",   32'(bus.req),   32'd1);
        chk("t4_addr2",  bus.addr,       32'h400);
        chk("t4_valid2", 32'(ins_valid), 32'd0);

        // 5: redirect coincident with ack and pop
        ack_drv  = 1'b1;
        id_ready = 1'b0;
        tick();
        chk("t5_pre_valid", 32'(ins_valid), 32'd1);
        chk("t5_pre_pc4",   ins_pc4,        32'h404);
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h800;
        #1;
        chk("t5_we",   32'(pc_we), 32'd1);
        chk("t5_next", pc_next,    32'h800);
        tick();
        redirect = 1'b0;
        ack_drv  = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("t5_valid", 32'(ins_valid), 32'd0);
        chk("t5_req",   32'(bus.req),   32'd0);
        chk("t5_pc",    pc,             32'h800);
        tick();
        chk("t5_req2",  32'(bus.req), 32'd1);
        chk("t5_addr2", bus.addr,     32'h800);

        // wrap-around of the sequential PC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        ack_drv  = 1'b1;
        tick();
        chk("w_idle_we",  32'(pc_we),   32'd0);
        chk("w_idle_req", 32'(bus.req), 32'd0);
        tick();
        chk("w_addr", bus.addr,   32'hFFFF_FFFC);
        chk("w_we",   32'(pc_we), 32'd1);
        chk("w_next", pc_next,    32'd0);
        tick();
        chk("w_pc4",   ins_pc4,  32'd0);
        chk("w_ins",   ins,      32'd3);
        chk("w_addr0", bus.addr, 32'd0);
        chk("w_pc",    pc,       32'd0);

        // 6: asynchronous reset mid-WAIT
        id_ready = 1'b1;
        tick();
        ack_drv = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        chk("r_req",   32'(bus.req),   32'd0);
        chk("r_valid", 32'(ins_valid), 32'd0);
        chk("r_addr",  bus.addr,       32'd0);
        chk("r_we",    32'(pc_we),     32'd0);
        chk("r_pc",    pc,             32'd4);
        #3;
        clrn = 1'b1;
        tick();
        chk("r_restart_req",  32'(bus.req), 32'd1);
        chk("r_restart_addr", bus.addr,     32'd4);
        ack_drv = 1'b1;
        #1;
        chk("r_next", pc_next, 32'd8);
        tick();
        chk("r_pc4", ins_pc4, 32'd8);
        chk("r_ins", ins,     ~32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
